vc_dest_router: RTL and testbench

Parametrised transaction-layer output stage that drains NUM_VC virtual-channel FIFOs and routes each word to one of NUM_DEST destination FIFOs. The destination is selected by a field in the word itself. It generalises the two-VC/two-destination final logic:
- channel and destination counts and data width are parameters;
- arbitration is fixed-priority or round-robin;
- a word is popped only when its destination has room (per-destination backpressure);
- words with an out-of-range destination field are detected and dropped.

It sits between the VC FIFOs and the destination (D) FIFOs of the PCI transmission path.

---
 rtl/vc_dest_router.sv | 107 ++++++++++
 tb/tb_vc_dest_router.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_dest_router.sv
// rtl/vc_dest_router.sv - drains NUM_VC VC FIFOs into NUM_DEST destination FIFOs routed by a header field
module vc_dest_router #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_VC     = 2,
  parameter int NUM_DEST   = 2,
  parameter int DEST_BITS  = $clog2(NUM_DEST),
  parameter int ARB_MODE   = 1
) (
  input  logic                           clk,
  input  logic                           reset_L,
  input  logic [NUM_VC*DATA_WIDTH-1:0]   data_in_vc,
  input  logic [NUM_VC-1:0]              empty_vc,
  input  logic [NUM_DEST-1:0]            almost_full_d,
  output logic [NUM_VC-1:0]              pop_vc,
  output logic [NUM_DEST-1:0]            push_d,
  output logic [NUM_DEST*DATA_WIDTH-1:0] data_out_d,
  output logic [NUM_VC-1:0]              error_vc,
  output logic                           idle
);
  localparam int VC_BITS   = $clog2(NUM_VC);
  localparam int DEST_SPAN = 1 << DEST_BITS;

  logic [VC_BITS-1:0]             r_rr_ptr;
  logic [NUM_DEST-1:0]            r_push_d;
  logic [NUM_DEST*DATA_WIDTH-1:0] r_data_out_d;
  logic [NUM_VC-1:0]              r_error_vc;
  logic                           r_idle;

  logic [DEST_SPAN-1:0]  w_dest_ok;
  logic [DEST_SPAN-1:0]  w_af_ext;
  logic [NUM_VC-1:0]     w_elig;
  logic [DEST_BITS-1:0]  w_head_dest;
  logic                  w_gnt_vld;
  logic [VC_BITS-1:0]    w_gnt;
  logic [VC_BITS-1:0]    w_cand;
  logic [DATA_WIDTH-1:0] w_gnt_word;
  logic [DEST_BITS-1:0]  w_gnt_dest;
  logic                  w_gnt_ok;

  // Field codes beyond NUM_DEST are invalid; padding them keeps all lookups in range.
  always_comb begin
    w_dest_ok = '0;
    w_dest_ok[NUM_DEST-1:0] = '1;
    w_af_ext = '1;
    w_af_ext[NUM_DEST-1:0] = almost_full_d;
  end

  always_comb begin
    w_elig = '0;
    w_head_dest = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      w_head_dest = data_in_vc[v*DATA_WIDTH + DATA_WIDTH - DEST_BITS +: DEST_BITS];
      w_elig[v] = !empty_vc[v] && (!w_dest_ok[w_head_dest] || !w_af_ext[w_head_dest]);
    end
  end

  // Scan from the far end so the candidate closest to the search start is written last.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt = '0;
    w_cand = '0;
    for (int n = NUM_VC - 1; n >= 0; n--) begin
      if (ARB_MODE == 1)
        w_cand = VC_BITS'((int'(r_rr_ptr) + n) % NUM_VC);
      else
        w_cand = VC_BITS'(n);
      if (w_elig[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt = w_cand;
      end
    end
  end

  always_comb begin
    w_gnt_word = data_in_vc[w_gnt*DATA_WIDTH +: DATA_WIDTH];
    w_gnt_dest = w_gnt_word[DATA_WIDTH-1 -: DEST_BITS];
    w_gnt_ok = w_dest_ok[w_gnt_dest];
    pop_vc = (w_gnt_vld && reset_L) ? (NUM_VC'(1) << w_gnt) : '0;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_rr_ptr     <= '0;
      r_push_d     <= '0;
      r_data_out_d <= '0;
      r_error_vc   <= '0;
      r_idle       <= 1'b1;
    end else begin
      r_push_d <= '0;
      r_idle   <= ~(|r_push_d) & (&empty_vc);
      if (w_gnt_vld) begin
        r_rr_ptr <= (32'(w_gnt) == 32'(NUM_VC - 1)) ? '0 : w_gnt + 1'b1;
        if (w_gnt_ok) begin
          r_push_d[w_gnt_dest] <= 1'b1;
          r_data_out_d[w_gnt_dest*DATA_WIDTH +: DATA_WIDTH] <= w_gnt_word;
        end else begin
          r_error_vc[w_gnt] <= 1'b1;
        end
      end
    end
  end

  assign push_d     = r_push_d;
  assign data_out_d = r_data_out_d;
  assign error_vc   = r_error_vc;
  assign idle       = r_idle;
endmodule

// File: tb/tb_vc_dest_router.sv
// tb/tb_vc_dest_router.sv - scoreboard bench: default instance (round-robin) and 3-destination fixed-priority instance
module tb_vc_dest_router;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_L;

  logic [11:0] din0;
  logic [1:0]  emp0, af0, pop0, push0, err0;
  logic [11:0] dout0;
  logic        idle0;
  logic [15:0] din1;
  logic [1:0]  emp1, pop1, err1;
  logic [2:0]  af1, push1;
  logic [23:0] dout1;
  logic        idle1;

  vc_dest_router u0 (
    .clk(clk), .reset_L(reset_L), .data_in_vc(din0), .empty_vc(emp0), .almost_full_d(af0),
    .pop_vc(pop0), .push_d(push0), .data_out_d(dout0), .error_vc(err0), .idle(idle0));

  vc_dest_router #(.DATA_WIDTH(8), .NUM_DEST(3), .ARB_MODE(0)) u1 (
    .clk(clk), .reset_L(reset_L), .data_in_vc(din1), .empty_vc(emp1), .almost_full_d(af1),
    .pop_vc(pop1), .push_d(push1), .data_out_d(dout1), .error_vc(err1), .idle(idle1));

  int vcq[2][2][$];
  int sbq[2][$];
  int rr[2];
  int lastd[2][3];
  logic [2:0] af[2];
  logic [1:0] experr[2];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dw(int i);   return (i == 0) ? 6 : 8; endfunction
  function automatic int nd(int i);   return (i == 0) ? 2 : 3; endfunction
  function automatic int db(int i);   return (i == 0) ? 1 : 2; endfunction
  function automatic int arbm(int i); return (i == 0) ? 1 : 0; endfunction
  function automatic logic [1:0] get_pop(int i); return (i == 0) ? pop0 : pop1; endfunction
  function automatic logic [1:0] get_err(int i); return (i == 0) ? err0 : err1; endfunction
  function automatic logic [2:0] get_push(int i); return (i == 0) ? {1'b0, push0} : push1; endfunction
  function automatic logic [31:0] get_dout(int i, int k);
    if (i == 0) return 32'(dout0[k*6 +: 6]);
    return 32'(dout1[k*8 +: 8]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: walk VCs in priority order and take the first head that may move.
  function automatic int model_grant(int i);
    int best, v, d;
    best = -1;
    for (int n = 0; n < 2; n++) begin
      v = (arbm(i) == 1) ? (rr[i] + n) % 2 : n;
      if (best < 0 && vcq[i][v].size() > 0) begin
        d = vcq[i][v][0] >> (dw(i) - db(i));
        if (d >= nd(i) || !af[i][d]) best = v;
      end
    end
    return best;
  endfunction

  task automatic drive();
    int w;
    for (int i = 0; i < 2; i++)
      for (int v = 0; v < 2; v++) begin
        w = (vcq[i][v].size() > 0) ? vcq[i][v][0] : int'($urandom_range(0, 255));
        if (i == 0) begin
          din0[v*6 +: 6] = 6'(w);
          emp0[v] = (vcq[i][v].size() == 0);
        end else begin
          din1[v*8 +: 8] = 8'(w);
          emp1[v] = (vcq[i][v].size() == 0);
        end
      end
    af0 = af[0][1:0];
    af1 = af[1];
  endtask

  task automatic load(input int i, input int v, input int w);
    vcq[i][v].push_back(w);
  endtask

  task automatic step();
    int g, w, d;
    logic [1:0] ep;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("error_vc%0d", i), get_err(i), experr[i]);
      g = model_grant(i);
      ep = (g < 0) ? 2'b00 : 2'(1 << g);
      chk($sformatf("pop_vc%0d", i), get_pop(i), ep);
      if (g >= 0) begin
        w = vcq[i][g].pop_front();
        d = w >> (dw(i) - db(i));
        if (d < nd(i)) sbq[i].push_back((cyc << 16) | (d << 8) | w);
        else experr[i][g] = 1'b1;
        if (arbm(i) == 1) rr[i] = (g + 1) % 2;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain();
    af[0] = '0;
    af[1] = '0;
    drive();
    for (int n = 0; n < 40; n++)
      if (vcq[0][0].size() + vcq[0][1].size() + vcq[1][0].size() + vcq[1][1].size() > 0) step();
    repeat (3) step();
    chk("idle0", idle0, 1);
    chk("idle1", idle1, 1);
  endtask

  task automatic monitor_inst(input int i);
    logic [2:0] p;
    int e, d;
    p = get_push(i);
    if (p != 0) begin
      if (sbq[i].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL push_unexpected inst%0d push_d=%b expected none", i, p);
      end else begin
        e = sbq[i].pop_front();
        d = (e >> 8) & 255;
        chk($sformatf("push_cycle%0d", i), e >> 16, cyc - 1);
        chk($sformatf("push_d%0d", i), p, 1 << d);
        lastd[i][d] = e & 255;
      end
    end else if (sbq[i].size() > 0 && (sbq[i][0] >> 16) < cyc) begin
      checks++;
      errors++;
      $display("FAIL push_missing inst%0d push_d=0 expected entry %0h", i, sbq[i][0] & 16'hffff);
      void'(sbq[i].pop_front());
    end
    for (int k = 0; k < nd(i); k++) chk($sformatf("data_out_d%0d_%0d", i, k), get_dout(i, k), lastd[i][k]);
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) for (int i = 0; i < 2; i++) monitor_inst(i);
  end

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      sbq[i].delete();
      rr[i] = 0;
      experr[i] = '0;
      for (int k = 0; k < 3; k++) lastd[i][k] = 0;
    end
  endtask

  initial begin
    reset_L = 1'b0;
    af[0] = '0;
    af[1] = '0;
    clear_model();
    load(0, 0, 6'h01); load(0, 1, 6'h02); load(1, 0, 8'h11); load(1, 1, 8'h52);
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pop0", pop0, 0);   chk("rst_pop1", pop1, 0);
    chk("rst_push0", push0, 0); chk("rst_push1", push1, 0);
    chk("rst_dout0", dout0, 0); chk("rst_dout1", dout1, 0);
    chk("rst_err0", err0, 0);   chk("rst_err1", err1, 0);
    chk("rst_idle0", idle0, 1); chk("rst_idle1", idle1, 1);
    @(posedge clk);
    #1 reset_L = 1'b1;
    mon_en = 1'b1;
    #1 chk("first_grant0", pop0, 2'b01);
    chk("first_grant1", pop1, 2'b01);
    drain();

    load(0, 0, 6'h25);
    drive();
    step();
    chk("route_push", push0, 2'b10);
    chk("route_data", dout0[11:6], 6'h25);
    drain();

    for (int j = 0; j < 3; j++) begin
      load(0, 0, 1 + j); load(0, 1, 9 + j);
      load(1, 0, 8'h01 + j); load(1, 1, 8'h21 + j);
    end
    drive();
    drain();

    af[0] = 3'b001;
    load(0, 0, 6'h0A); load(0, 1, 6'h2B);
    drive();
    repeat (3) step();
    af[0] = '0;
    drive();
    step();
    drain();

    load(1, 1, 8'hC3);
    drive();
    step();
    chk("invalid_err", err1, 2'b10);
    chk("invalid_nopush", push1, 0);
    drain();

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        for (int v = 0; v < 2; v++)
          if (vcq[i][v].size() < 4 && $urandom_range(0, 1) == 1)
            load(i, v, int'($urandom_range(0, (i == 0) ? 63 : 255)));
        af[i] = 3'($urandom_range(0, 7));
      end
      drive();
      step();
    end
    drain();

    // Asynchronous reset while a push is on the outputs.
    load(0, 0, 6'h07); load(0, 1, 6'h08);
    drive();
    step();
    mon_en = 1'b0;
    chk("mid_push", push0, 2'b01);
    #2 reset_L = 1'b0;
    #1 chk("mid_rst_push0", push0, 0);
    chk("mid_rst_dout0", dout0, 0);
    chk("mid_rst_err1", err1, 0);
    chk("mid_rst_pop0", pop0, 0);
    clear_model();
    @(posedge clk);
    #1 reset_L = 1'b1;
    load(0, 0, 6'h09);
    drive();
    #1 chk("rr_restart", pop0, 2'b01);
    mon_en = 1'b1;
    step();
    drain();

    chk("sb_empty0", sbq[0].size(), 0);
    chk("sb_empty1", sbq[1].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
